// File: rtl/block_mem_writer_pkg.sv
// ----------------------------------------------------------------------------
// block_mem_writer_pkg
// Shared definitions for the sprite memory writer and the sprite readers:
// default sprite geometry, address width, 2-bit pixel codes and the writer
// FSM state encoding.
// No ports (package).
// ----------------------------------------------------------------------------
package block_mem_writer_pkg;

  localparam int SPRITE_WIDTH  = 78;
  localparam int SPRITE_HEIGHT = 53;
  localparam int ADDR_W        = 13;

  // Pixel codes stored in sprite memory.
  localparam logic [1:0] PIX_BLACK   = 2'b00;
  localparam logic [1:0] PIX_COLOR_A = 2'b01;
  localparam logic [1:0] PIX_COLOR_B = 2'b10;
  localparam logic [1:0] PIX_WHITE   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_FINISH = 2'd2
  } wr_state_t;

  // Address of the final word of a load of the given depth.
  function automatic logic [ADDR_W-1:0] last_addr(input int depth);
    return ADDR_W'(depth - 1);
  endfunction

endpackage

// File: rtl/block_mem_writer.sv
// ----------------------------------------------------------------------------
// block_mem_writer
// Streams pixel beats into an external sprite memory, row-major from address
// 0 up to DEPTH-1, then pulses done and returns to idle.
//
// Optional feature: define BLOCK_WR_RLE_EN to treat each beat as
// {run[5:0], pixel[1:0]} and write the pixel run+1 times. Runs that would
// pass the end of the sprite are truncated and flag overflow. With the macro
// undefined every beat writes exactly one pixel and in_data[7:2] is ignored.
//
// Ports:
//   vclk      in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   start     in   one-cycle load request (honoured only when idle)
//   in_data   in   [7:0] pixel beat
//   in_valid  in   beat qualifier
//   in_ready  out  beat is accepted when in_valid & in_ready
//   wr_en     out  memory write strobe
//   wr_addr   out  [12:0] write address (y*WIDTH+x)
//   wr_data   out  [1:0] pixel code
//   busy      out  load in progress
//   done      out  one-cycle completion pulse
//   overflow  out  sticky: a run was truncated at the end of the sprite
// ----------------------------------------------------------------------------
module block_mem_writer
  import block_mem_writer_pkg::*;
#(
  parameter int WIDTH  = SPRITE_WIDTH,
  parameter int HEIGHT = SPRITE_HEIGHT,
  parameter int DEPTH  = WIDTH * HEIGHT
) (
  input  logic              vclk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [1:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam logic [ADDR_W-1:0] LAST = last_addr(DEPTH);

  wr_state_t         state;
  logic [ADDR_W-1:0] cnt;
  logic              accept;

  assign accept = in_valid && in_ready;

`ifdef BLOCK_WR_RLE_EN
  logic [5:0] run_left;   // repeat writes still owed for the current beat
  logic [5:0] beat_run;
  assign beat_run = in_data[7:2];
`else
  logic unused_run_bits;
  assign unused_run_bits = ^in_data[7:2];
`endif

  always_ff @(posedge vclk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
`ifdef BLOCK_WR_RLE_EN
      run_left <= '0;
`endif
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_LOAD;
            cnt      <= '0;
            overflow <= 1'b0;
            busy     <= 1'b1;
            in_ready <= 1'b1;
          end
        end

        ST_LOAD: begin
`ifdef BLOCK_WR_RLE_EN
          if (run_left != 6'd0) begin
            // Repeat write of the pixel already sitting on wr_data.
            wr_en    <= 1'b1;
            wr_addr  <= cnt;
            run_left <= run_left - 6'd1;
            if (cnt == LAST) begin
              state    <= ST_FINISH;
              done     <= 1'b1;
              in_ready <= 1'b0;
              run_left <= '0;
              if (run_left != 6'd1) overflow <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
              // Reopen the input alongside the final write of the run.
              if (run_left == 6'd1) in_ready <= 1'b1;
            end
          end else if (accept) begin
            wr_en    <= 1'b1;
            wr_addr  <= cnt;
            wr_data  <= in_data[1:0];
            run_left <= beat_run;
            if (cnt == LAST) begin
              state    <= ST_FINISH;
              done     <= 1'b1;
              in_ready <= 1'b0;
              run_left <= '0;
              if (beat_run != 6'd0) overflow <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
              if (beat_run != 6'd0) in_ready <= 1'b0;
            end
          end
`else
          if (accept) begin
            wr_en   <= 1'b1;
            wr_addr <= cnt;
            wr_data <= in_data[1:0];
            if (cnt == LAST) begin
              state    <= ST_FINISH;
              done     <= 1'b1;
              in_ready <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`endif
        end

        ST_FINISH: begin
          state    <= ST_IDLE;
          busy     <= 1'b0;
          in_ready <= 1'b0;
        end

        default: begin
          state    <= ST_IDLE;
          busy     <= 1'b0;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_block_mem_writer.sv
// ----------------------------------------------------------------------------
// tb_block_mem_writer
// Randomised bench for block_mem_writer. Each scenario builds the list of
// beats it sends, derives the expected write list from the pixel/run rules,
// and compares it with the writes captured from the memory port.
// ----------------------------------------------------------------------------
module tb_block_mem_writer;

  localparam int WIDTH  = 78;
  localparam int HEIGHT = 53;
  localparam int DEPTH  = WIDTH * HEIGHT;

  logic        vclk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [12:0] wr_addr;
  logic [1:0]  wr_data;
  logic        busy;
  logic        done;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Captured memory-port activity.
  int wq_addr[$];
  int wq_data[$];
  int wq_cyc[$];
  int done_cnt;
  int done_last_cnt;
  int range_bad;

  // Stimulus and reference.
  logic [7:0] beats[$];
  int exp_addr[$];
  int exp_data[$];
  int fed;
  bit timeout;

  block_mem_writer #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
    .vclk(vclk), .rst(rst), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .overflow(overflow)
  );

  always #5 vclk = ~vclk;

  always @(posedge vclk) cyc <= cyc + 1;

  always @(negedge vclk) begin
    if (wr_en) begin
      wq_addr.push_back(int'(wr_addr));
      wq_data.push_back(int'(wr_data));
      wq_cyc.push_back(cyc);
      if (int'(wr_addr) >= DEPTH) range_bad++;
    end
    if (done) begin
      done_cnt++;
      if (wr_en && int'(wr_addr) == DEPTH - 1) done_last_cnt++;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge vclk);
    #1;
  endtask

  task automatic clear_all();
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
    done_cnt = 0; done_last_cnt = 0; range_bad = 0;
    beats.delete(); exp_addr.delete(); exp_data.delete();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic abort_load();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Reference: expand beats into pixel writes from address 0, stopping at the
  // end of the sprite. Returns whether any pixel demand was cut off.
  function automatic bit build_expected(input bit rle);
    int a = 0;
    bit cut = 0;
    foreach (beats[i]) begin
      int reps = rle ? (int'(beats[i][7:2]) + 1) : 1;
      if (a >= DEPTH) break;
      for (int k = 0; k < reps; k++) begin
        if (a < DEPTH) begin
          exp_addr.push_back(a);
          exp_data.push_back(int'(beats[i][1:0]));
          a++;
        end else begin
          cut = 1;
        end
      end
    end
    return cut;
  endfunction

  // mode 0: valid every cycle, 1: random valid held until accepted,
  // 2: valid on alternate cycles.
  task automatic feed(input int mode);
    int budget = 0;
    int limit = 3 * beats.size() + 200;
    bit acc;
    fed = 0;
    while (fed < beats.size() && budget < limit && busy) begin
      case (mode)
        0: in_valid = 1'b1;
        1: if (!(in_valid && !in_ready)) in_valid = 1'($urandom_range(0, 1));
        default: in_valid = (budget % 2 == 0);
      endcase
      in_data = beats[fed];
      acc = in_valid && in_ready;
      tick();
      if (acc) fed++;
      budget++;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    tick();
    while (busy && n < 300) begin
      tick();
      n++;
    end
    timeout = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    tick(); tick();
    checks++; if ({wr_en, in_ready, busy, done, overflow} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b want 00000", {wr_en, in_ready, busy, done, overflow});
    end
    checks++; if ({wr_addr, wr_data} !== 15'd0) begin
      errors++; $display("FAIL reset_addr_data got addr %0d data %0d want 0 0", wr_addr, wr_data);
    end
    rst = 1'b0;
    tick();
    checks++; if ({in_ready, busy} !== 2'b00) begin
      errors++; $display("FAIL reset_idle got ready/busy %b want 00", {in_ready, busy});
    end
  endtask

  task automatic test_idle_ignore();
    int ready_seen = 0;
    clear_all();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data = 8'($urandom);
      tick();
      if (in_ready) ready_seen++;
    end
    in_valid = 1'b0;
    tick();
    checks++; if (wq_addr.size() != 0 || ready_seen != 0) begin
      errors++; $display("FAIL idle_ignore got writes %0d ready %0d want 0 0", wq_addr.size(), ready_seen);
    end
  endtask

  task automatic test_full_load(input int mode, input string tag);
    int bad = 0;
    int first_bad = -1;
    clear_all();
    for (int i = 0; i < DEPTH; i++) begin
`ifdef BLOCK_WR_RLE_EN
      beats.push_back({6'd0, 2'($urandom)});
`else
      beats.push_back(8'($urandom));
`endif
    end
`ifdef BLOCK_WR_RLE_EN
    void'(build_expected(1));
`else
    void'(build_expected(0));
`endif
    do_start();
    checks++; if (busy !== 1'b1 || in_ready !== 1'b1) begin
      errors++; $display("FAIL %s_start got busy %b ready %b want 1 1", tag, busy, in_ready);
    end
    feed(mode);
    wait_idle();
    checks++; if (fed != DEPTH || timeout) begin
      errors++; $display("FAIL %s_consumed got %0d timeout %0b want %0d 0", tag, fed, timeout, DEPTH);
    end
    checks++; if (wq_addr.size() != exp_addr.size()) begin
      errors++; $display("FAIL %s_write_count got %0d want %0d", tag, wq_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < wq_addr.size() && i < exp_addr.size(); i++) begin
      if (wq_addr[i] != exp_addr[i] || wq_data[i] != exp_data[i]) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    checks++; if (bad != 0) begin
      errors++; $display("FAIL %s_writes got %0d bad entries (first %0d) want 0", tag, bad, first_bad);
    end
    if (mode == 0 && wq_cyc.size() == DEPTH) begin
      checks++; if (wq_cyc[DEPTH-1] - wq_cyc[0] != DEPTH - 1) begin
        errors++; $display("FAIL %s_streaming got span %0d want %0d", tag, wq_cyc[DEPTH-1] - wq_cyc[0], DEPTH - 1);
      end
    end
    checks++; if (done_cnt != 1 || done_last_cnt != 1) begin
      errors++; $display("FAIL %s_done got pulses %0d with_last %0d want 1 1", tag, done_cnt, done_last_cnt);
    end
    checks++; if ({busy, in_ready, overflow} !== 3'b000 || range_bad != 0) begin
      errors++; $display("FAIL %s_end got busy/ready/ovf %b range_bad %0d want 000 0", tag, {busy, in_ready, overflow}, range_bad);
    end
  endtask

  task automatic test_toggle();
    int bad = 0;
    clear_all();
    for (int i = 0; i < 200; i++) beats.push_back({6'd0, 2'($urandom)});
    void'(build_expected(0));
    do_start();
    feed(2);
    tick();
    checks++; if (wq_addr.size() != 200) begin
      errors++; $display("FAIL toggle_count got %0d want 200", wq_addr.size());
    end
    for (int i = 0; i < wq_addr.size() && i < 200; i++) begin
      if (wq_addr[i] != exp_addr[i] || wq_data[i] != exp_data[i]) bad++;
      if (i > 0 && wq_cyc[i] - wq_cyc[i-1] != 2) bad++;
    end
    checks++; if (bad != 0) begin
      errors++; $display("FAIL toggle_sequence got %0d bad entries want 0", bad);
    end
    abort_load();
  endtask

  task automatic test_mid_start();
    int last;
    clear_all();
    for (int i = 0; i < 51; i++) beats.push_back({6'd0, 2'($urandom)});
    do_start();
    feed(1);
    start = 1'b1;
    tick();
    start = 1'b0;
    beats.delete();
    beats.push_back({6'd0, 2'b10});
    feed(1);
    tick();
    last = (wq_addr.size() > 0) ? wq_addr[wq_addr.size()-1] : -1;
    checks++; if (wq_addr.size() != 52 || last != 51) begin
      errors++; $display("FAIL mid_start got %0d writes last addr %0d want 52 51", wq_addr.size(), last);
    end
    checks++; if (busy !== 1'b1 || done_cnt != 0) begin
      errors++; $display("FAIL mid_start_busy got busy %b done %0d want 1 0", busy, done_cnt);
    end
    abort_load();
  endtask

  task automatic test_reset_mid();
    clear_all();
    for (int i = 0; i < 101; i++) beats.push_back({6'd0, 2'($urandom)});
    do_start();
    feed(0);
    checks++; if (wr_en !== 1'b1 || wr_addr !== 13'd100) begin
      errors++; $display("FAIL reset_mid_pre got wr_en %b addr %0d want 1 100", wr_en, wr_addr);
    end
    #2 rst = 1'b1;
    #1;
    checks++; if ({wr_en, in_ready, busy, done, overflow} !== 5'b0 || {wr_addr, wr_data} !== 15'd0) begin
      errors++; $display("FAIL reset_mid_async got flags %b addr %0d data %0d want 00000 0 0",
                         {wr_en, in_ready, busy, done, overflow}, wr_addr, wr_data);
    end
    tick(); tick();
    rst = 1'b0;
    clear_all();
    tick(); tick();
    checks++; if (busy !== 1'b0 || done_cnt != 0 || wq_addr.size() != 0) begin
      errors++; $display("FAIL reset_mid_no_resume got busy %b done %0d writes %0d want 0 0 0", busy, done_cnt, wq_addr.size());
    end
    for (int i = 0; i < 5; i++) beats.push_back({6'd0, 2'($urandom)});
    do_start();
    feed(1);
    tick();
    checks++; if (wq_addr.size() != 5 || wq_addr[0] != 0) begin
      errors++; $display("FAIL reset_mid_restart got %0d writes first %0d want 5 0",
                         wq_addr.size(), (wq_addr.size() > 0) ? wq_addr[0] : -1);
    end
    abort_load();
  endtask

`ifdef BLOCK_WR_RLE_EN
  task automatic test_rle_run();
    int lowcnt = 0;
    int bad = 0;
    clear_all();
    beats.push_back({6'd63, 2'b01});
    void'(build_expected(1));
    do_start();
    in_valid = 1'b1;
    in_data = beats[0];
    tick();
    in_valid = 1'b0;
    while (!in_ready && lowcnt < 200) begin
      lowcnt++;
      tick();
    end
    tick();
    checks++; if (lowcnt != 63) begin
      errors++; $display("FAIL rle_ready_low got %0d cycles want 63", lowcnt);
    end
    checks++; if (wq_addr.size() != 64) begin
      errors++; $display("FAIL rle_run_count got %0d want 64", wq_addr.size());
    end
    for (int i = 0; i < wq_addr.size() && i < 64; i++)
      if (wq_addr[i] != exp_addr[i] || wq_data[i] != exp_data[i]) bad++;
    checks++; if (bad != 0) begin
      errors++; $display("FAIL rle_run_writes got %0d bad want 0", bad);
    end
    abort_load();
  endtask

  task automatic test_rle_overflow();
    int left = 4130;
    int bad = 0;
    bit exp_ovf;
    clear_all();
    while (left > 0) begin
      int r = $urandom_range(0, (left - 1 < 63) ? left - 1 : 63);
      beats.push_back({6'(r), 2'($urandom)});
      left -= r + 1;
    end
    beats.push_back({6'd9, 2'b00});
    exp_ovf = build_expected(1);
    do_start();
    feed(1);
    wait_idle();
    checks++; if (fed != beats.size() || timeout) begin
      errors++; $display("FAIL rle_ovf_consumed got %0d timeout %0b want %0d 0", fed, timeout, beats.size());
    end
    checks++; if (wq_addr.size() != exp_addr.size()) begin
      errors++; $display("FAIL rle_ovf_count got %0d want %0d", wq_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < wq_addr.size() && i < exp_addr.size(); i++)
      if (wq_addr[i] != exp_addr[i] || wq_data[i] != exp_data[i]) bad++;
    checks++; if (bad != 0 || range_bad != 0) begin
      errors++; $display("FAIL rle_ovf_writes got %0d bad range_bad %0d want 0 0", bad, range_bad);
    end
    checks++; if (overflow !== exp_ovf || done_cnt != 1) begin
      errors++; $display("FAIL rle_ovf_flag got ovf %b done %0d want %b 1", overflow, done_cnt, exp_ovf);
    end
    do_start();
    checks++; if (overflow !== 1'b0) begin
      errors++; $display("FAIL rle_ovf_clear got %b want 0", overflow);
    end
    abort_load();
  endtask
`endif

  initial begin
    test_reset();
    test_idle_ignore();
    test_full_load(0, "full_stream");
    test_full_load(1, "full_random");
    test_toggle();
    test_mid_start();
    test_reset_mid();
`ifdef BLOCK_WR_RLE_EN
    test_rle_run();
    test_rle_overflow();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
